// File: rtl/sram_lsu_pkg.sv
// Shared encodings for the SRAM load/store unit: access sizes and FSM states.
package sram_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/sram_lsu_align.sv
// Lane enables, store replication and load extract/extend; purely combinational, no backpressure.
module sram_lsu_align
  import sram_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic [3:0]  lanes,
  output logic [31:0] wr_word,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half accesses only look at adr[1]; the low bit is ignored here.
  assign byte_sel = rd_word[{adr_lo, 3'b000} +: 8];
  assign half_sel = rd_word[{adr_lo[1], 4'b0000} +: 16];

  always_comb begin
    lanes   = 4'b0000;
    wr_word = wdata;
    rdata   = rd_word;
    case (size)
      SZ_BYTE: begin
        lanes   = 4'b0001 << adr_lo;
        wr_word = {4{wdata[7:0]}};
        rdata   = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        lanes   = 4'b0011 << {adr_lo[1], 1'b0};
        wr_word = {2{wdata[15:0]}};
        rdata   = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      SZ_WORD: lanes = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_lsu.sv
// Load/store unit for a single-port async-read SRAM; LSU_MISALIGN_CHK_EN rejects misaligned half/word.
// Response 2 cycles after handshake, one access per 2 cycles; req_ready drops while a response is held.
module sram_lsu
  import sram_lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  state_t      state, state_nxt;
  logic        r_we, r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_adr, r_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        hs, reject, misalign;
  logic [3:0]  lanes;
  logic [31:0] wr_word, ld_data;

  assign req_ready = ~rst & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign hs        = req_valid & req_ready;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((r_size == SZ_HALF) & r_adr[0]) |
                    ((r_size == SZ_WORD) & (r_adr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = (r_size == SZ_RSVD) | (r_adr >= ADDR_LIMIT) | misalign;

  sram_lsu_align u_align (
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .adr_lo      (r_adr[1:0]),
    .wdata       (r_wdata),
    .rd_word     (mem_dout),
    .lanes       (lanes),
    .wr_word     (wr_word),
    .rdata       (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = hs ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_BYTE;
      r_adr      <= '0;
      r_wdata    <= '0;
    end else if (hs) begin
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_size     <= req_size;
      r_adr      <= req_adr;
      r_wdata    <= req_wdata;
    end
  end

  // Result is captured once in ACCESS so it stays stable for the whole RESP stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      err_q   <= reject;
      rdata_q <= (reject | r_we) ? 32'h0 : ld_data;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_adr   = r_adr;
    mem_din   = wr_word;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    if (!rst) begin
      if ((state == ACCESS) && !reject) begin
        mem_en = 1'b1;
        if (r_we) mem_we = lanes;
      end
      if (state == RESP) begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_lsu.sv
// Directed bench for sram_lsu with a behavioural byte-lane SRAM model.
module tb_sram_lsu;
  import sram_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_adr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_adr, mem_din, mem_dout;

  logic [31:0] mem [0:16383];
  int          en_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sram_lsu #(.ADDR_LIMIT(32'h0001_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_adr      (req_adr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_adr      (mem_adr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  assign mem_dout = mem[mem_adr[15:2]];

  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_adr[15:2]][8*i +: 8] <= mem_din[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a posedge with the DUT idle; returns idle.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] adr, input logic [31:0] wdata,
                         output logic a_en, output logic [3:0] a_we, output logic [31:0] a_din,
                         output logic r_vld, output logic r_err, output logic [31:0] r_data);
    int cnt;
    req_we = we; req_size = size; req_unsigned = uns; req_adr = adr; req_wdata = wdata;
    req_valid = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    a_en = mem_en; a_we = mem_we; a_din = mem_din;
    @(posedge clk); #1;
    r_vld = rsp_valid; r_err = rsp_err; r_data = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic        a_en, r_vld, r_err, hs;
  logic [3:0]  a_we;
  logic [31:0] a_din, r_data;
  int          en_before, n_hs, n_rsp, seen;
  int          hs_cyc [4];
  int          rsp_cyc [4];
  logic [1:0]  p_size [4];
  logic        p_uns [4];
  logic [31:0] p_adr [4];
  logic [31:0] p_exp [4];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_adr = '0; req_wdata = '0; rsp_ready = 1'b0;
    p_size[0] = SZ_WORD; p_uns[0] = 1'b0; p_adr[0] = 32'h40;  p_exp[0] = 32'h80FF_7F01;
    p_size[1] = SZ_HALF; p_uns[1] = 1'b0; p_adr[1] = 32'h42;  p_exp[1] = 32'hFFFF_80FF;
    p_size[2] = SZ_BYTE; p_uns[2] = 1'b1; p_adr[2] = 32'h102; p_exp[2] = 32'h0000_00AB;
    p_size[3] = SZ_BYTE; p_uns[3] = 1'b0; p_adr[3] = 32'h41;  p_exp[3] = 32'h0000_007F;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'h0);
    chk("rst_mem_en",    {31'b0, mem_en}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // store byte / load byte
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h102, 32'h1234_56AB, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("sb_en",   {31'b0, a_en}, 32'h1);
    chk("sb_we",   {28'b0, a_we}, 32'h4);
    chk("sb_din",  a_din, 32'hABAB_ABAB);
    chk("sb_vld",  {31'b0, r_vld}, 32'h1);
    chk("sb_err",  {31'b0, r_err}, 32'h0);
    chk("sb_data", r_data, 32'h0);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h102, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("lbu_we",   {28'b0, a_we}, 32'h0);
    chk("lbu_data", r_data, 32'h0000_00AB);
    run_req(1'b0, SZ_BYTE, 1'b0, 32'h102, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("lb_data", r_data, 32'hFFFF_FFAB);

    // word preload, half/word loads, half store
    run_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h80FF_7F01, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("sw_we",  {28'b0, a_we}, 32'hF);
    chk("sw_din", a_din, 32'h80FF_7F01);
    run_req(1'b0, SZ_HALF, 1'b0, 32'h42, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("lh_42", r_data, 32'hFFFF_80FF);
    run_req(1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("lhu_42", r_data, 32'h0000_80FF);
    run_req(1'b0, SZ_HALF, 1'b0, 32'h40, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("lh_40", r_data, 32'h0000_7F01);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("lw_40", r_data, 32'h80FF_7F01);
    run_req(1'b1, SZ_HALF, 1'b0, 32'h202, 32'hCDEF_1234, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("sh_we",  {28'b0, a_we}, 32'hC);
    chk("sh_din", a_din, 32'h1234_1234);

    // rejected accesses never touch the SRAM
    en_before = en_cnt;
    run_req(1'b0, SZ_WORD, 1'b0, 32'h0001_0000, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("oob_err",  {31'b0, r_err}, 32'h1);
    chk("oob_data", r_data, 32'h0);
    chk("oob_en",   en_cnt - en_before, 32'h0);
    en_before = en_cnt;
    run_req(1'b1, SZ_RSVD, 1'b0, 32'h40, 32'hFFFF_FFFF, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("sz3_err",  {31'b0, r_err}, 32'h1);
    chk("sz3_data", r_data, 32'h0);
    chk("sz3_en",   en_cnt - en_before, 32'h0);
    chk("sz3_mem",  mem[16], 32'h80FF_7F01);

    // back-to-back: handshakes at cycles 0,2,4,6, responses at 2,4,6,8
    n_hs = 0; n_rsp = 0;
    req_we = 1'b0; req_wdata = '0;
    req_size = p_size[0]; req_unsigned = p_uns[0]; req_adr = p_adr[0];
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (rsp_valid) begin
        if (n_rsp < 4) begin
          chk("pipe_data", rsp_rdata, p_exp[n_rsp]);
          rsp_cyc[n_rsp] = k;
        end
        n_rsp++;
      end
      if (hs) begin
        if (n_hs < 4) hs_cyc[n_hs] = k;
        n_hs++;
      end
      @(posedge clk); #1;
      if (hs) begin
        if (n_hs < 4) begin
          req_size = p_size[n_hs]; req_unsigned = p_uns[n_hs]; req_adr = p_adr[n_hs];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    chk("pipe_n_hs",  n_hs,  32'd4);
    chk("pipe_n_rsp", n_rsp, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("pipe_hs_cyc",  hs_cyc[i],  2 * i);
      chk("pipe_rsp_cyc", rsp_cyc[i], 2 * i + 2);
    end

    // stalled response holds and blocks new requests
    req_we = 1'b0; req_size = SZ_HALF; req_unsigned = 1'b1; req_adr = 32'h40; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_size = SZ_BYTE; req_adr = 32'h300; req_wdata = 32'h77;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_vld",   {31'b0, rsp_valid}, 32'h1);
      chk("stall_data",  rsp_rdata, 32'h0000_7F01);
      chk("stall_err",   {31'b0, rsp_err}, 32'h0);
      chk("stall_ready", {31'b0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall_done", {31'b0, rsp_valid}, 32'h0);

    // reset in the ACCESS cycle of a store
    req_we = 1'b1; req_size = SZ_BYTE; req_adr = 32'h102; req_wdata = 32'h55; req_valid = 1'b1;
    chk("racc_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("racc_we",    {28'b0, mem_we}, 32'h0);
    chk("racc_en",    {31'b0, mem_en}, 32'h0);
    chk("racc_rdy",   {31'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("racc_no_rsp", seen, 32'd0);
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h102, 32'h0, a_en, a_we, a_din, r_vld, r_err, r_data);
    chk("racc_mem", r_data, 32'h0000_00AB);

    // misaligned word store
    run_req(1'b1, SZ_WORD, 1'b0, 32'h41, 32'hDEAD_BEEF, a_en, a_we, a_din, r_vld, r_err, r_data);
`ifdef LSU_MISALIGN_CHK_EN
    chk("mis_err", {31'b0, r_err}, 32'h1);
    chk("mis_en",  {31'b0, a_en}, 32'h0);
    chk("mis_mem", mem[16], 32'h80FF_7F01);
`else
    chk("mis_err", {31'b0, r_err}, 32'h0);
    chk("mis_we",  {28'b0, a_we}, 32'hF);
    chk("mis_mem", mem[16], 32'hDEAD_BEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
